// File: rtl/save_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : save_ctrl_pkg
// Purpose  : Types shared by the save controller and its arbiter:
//            the controller FSM state encoding and the requester identifier.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package save_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage
`default_nettype wire

// File: rtl/save_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : save_rr_arb
// Purpose  : Two-requester round-robin arbiter. On a tie the requester that
//            did not win last time is chosen; a lone requester always wins.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            req_a, req_b - request lines
//            grant_en     - the caller accepts this cycle's winner
//            any_req      - at least one request is present
//            winner       - identity of the requester that would be granted
// Revision : 1.0 - initial release
// ============================================================================
module save_rr_arb
  import save_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    req_a,
  input  logic    req_b,
  input  logic    grant_en,
  output logic    any_req,
  output req_id_t winner
);

  req_id_t last_grant;

  always_comb begin
    any_req = req_a | req_b;
    winner  = REQ_A;
    if (req_a && req_b) begin
      winner = (last_grant == REQ_B) ? REQ_A : REQ_B;
    end else if (req_b) begin
      winner = REQ_B;
    end
  end

  // Starts at B so that A wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_B;
    end else if (grant_en) begin
      last_grant <= winner;
    end
  end

endmodule
`default_nettype wire

// File: rtl/save_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : save_ctrl
// Purpose  : Arbitrates save requests from two requesters into a ring of N
//            slots. Drives a one-hot per-slot write enable plus a shared
//            data bus, acknowledges the winner, and supports a bulk clear.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            req_a/num_a     - requester A handshake and data
//            req_b/num_b     - requester B handshake and data
//            clr             - one-cycle pulse, clears every slot
//            ok_save         - one-hot slot write enable (all ones on clear)
//            num             - registered data bus to the slots
//            ack_a, ack_b    - one-cycle acknowledges
//            wr_ptr          - next slot to write
//            count, full     - occupancy and full flag
// Revision : 1.0 - initial release
// ============================================================================
module save_ctrl
  import save_ctrl_pkg::*;
#(
  parameter  int W         = 8,
  parameter  int N         = 4,
  parameter  int OVERWRITE = 0,
  localparam int PW        = $clog2(N),
  localparam int CW        = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic [W-1:0]  num_a,
  input  logic          req_b,
  input  logic [W-1:0]  num_b,
  input  logic          clr,
  output logic [N-1:0]  ok_save,
  output logic [W-1:0]  num,
  output logic          ack_a,
  output logic          ack_b,
  output logic [PW-1:0] wr_ptr,
  output logic [CW-1:0] count,
  output logic          full
);

  localparam logic [CW-1:0] COUNT_MAX = CW'(N);

  state_t  state, state_nxt;
  req_id_t owner, owner_nxt;
  logic    pend_clr, pend_nxt;

  logic [N-1:0]  ok_save_nxt;
  logic [W-1:0]  num_nxt;
  logic          ack_a_nxt, ack_b_nxt;
  logic [PW-1:0] wr_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic          full_nxt;

  logic    grant_en;
  logic    any_req;
  req_id_t winner;
  logic    grantable;

  assign grantable = !full || (OVERWRITE != 0);

  save_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .req_b    (req_b),
    .grant_en (grant_en),
    .any_req  (any_req),
    .winner   (winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= REQ_A;
      pend_clr <= 1'b0;
      ok_save  <= '0;
      num      <= '0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      pend_clr <= pend_nxt;
      ok_save  <= ok_save_nxt;
      num      <= num_nxt;
      ack_a    <= ack_a_nxt;
      ack_b    <= ack_b_nxt;
      wr_ptr   <= wr_ptr_nxt;
      count    <= count_nxt;
      full     <= full_nxt;
    end
  end

  // Every output is computed one cycle ahead so the registered value lines
  // up with the state it belongs to (e.g. ok_save is high during WRITE).
  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    pend_nxt    = pend_clr | clr;
    ok_save_nxt = '0;
    num_nxt     = num;
    ack_a_nxt   = 1'b0;
    ack_b_nxt   = 1'b0;
    wr_ptr_nxt  = wr_ptr;
    count_nxt   = count;
    grant_en    = 1'b0;

    case (state)
      ST_IDLE: begin
        // A clear arriving this very cycle counts as pending and wins.
        if (pend_clr || clr) begin
          state_nxt   = ST_CLEAR;
          ok_save_nxt = '1;
          num_nxt     = '0;
          wr_ptr_nxt  = '0;
          count_nxt   = '0;
          pend_nxt    = 1'b0;
        end else if (any_req && grantable) begin
          state_nxt           = ST_WRITE;
          grant_en            = 1'b1;
          owner_nxt           = winner;
          num_nxt             = (winner == REQ_A) ? num_a : num_b;
          ok_save_nxt[wr_ptr] = 1'b1;
        end
      end
      ST_WRITE: begin
        state_nxt  = ST_ACK;
        ack_a_nxt  = (owner == REQ_A);
        ack_b_nxt  = (owner == REQ_B);
        wr_ptr_nxt = wr_ptr + 1'b1;
        // Overwriting a full ring keeps the count at N.
        if (count != COUNT_MAX) begin
          count_nxt = count + 1'b1;
        end
      end
      ST_ACK: begin
        state_nxt = ST_IDLE;
      end
      ST_CLEAR: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    full_nxt = (count_nxt == COUNT_MAX);
  end

endmodule
`default_nettype wire

// File: tb/tb_save_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_save_ctrl
// Purpose  : Self-checking bench for save_ctrl. Instance 0 stalls when full,
//            instance 1 overwrites when full.
// Revision : 1.0 - initial release
// ============================================================================
module tb_save_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     [2];
  logic       req_a   [2];
  logic       req_b   [2];
  logic       clr     [2];
  logic [7:0] num_a   [2];
  logic [7:0] num_b   [2];
  logic [3:0] ok_save [2];
  logic [7:0] num     [2];
  logic       ack_a   [2];
  logic       ack_b   [2];
  logic [1:0] wr_ptr  [2];
  logic [2:0] count   [2];
  logic       full    [2];

  save_ctrl #(.W(8), .N(4), .OVERWRITE(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_a(req_a[0]), .num_a(num_a[0]),
    .req_b(req_b[0]), .num_b(num_b[0]), .clr(clr[0]),
    .ok_save(ok_save[0]), .num(num[0]), .ack_a(ack_a[0]), .ack_b(ack_b[0]),
    .wr_ptr(wr_ptr[0]), .count(count[0]), .full(full[0])
  );

  save_ctrl #(.W(8), .N(4), .OVERWRITE(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_a(req_a[1]), .num_a(num_a[1]),
    .req_b(req_b[1]), .num_b(num_b[1]), .clr(clr[1]),
    .ok_save(ok_save[1]), .num(num[1]), .ack_a(ack_a[1]), .ack_b(ack_b[1]),
    .wr_ptr(wr_ptr[1]), .count(count[1]), .full(full[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input int d, input string t, input logic [3:0] eok,
                         input logic [7:0] enm, input logic eaa, input logic eab,
                         input logic [1:0] ewr, input logic [2:0] ecnt, input logic ef);
    chk({t, ".ok_save"}, 32'(ok_save[d]), 32'(eok));
    chk({t, ".num"},     32'(num[d]),     32'(enm));
    chk({t, ".ack_a"},   32'(ack_a[d]),   32'(eaa));
    chk({t, ".ack_b"},   32'(ack_b[d]),   32'(eab));
    chk({t, ".wr_ptr"},  32'(wr_ptr[d]),  32'(ewr));
    chk({t, ".count"},   32'(count[d]),   32'(ecnt));
    chk({t, ".full"},    32'(full[d]),    32'(ef));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1; req_a[d] = 1'b0; req_b[d] = 1'b0; clr[d] = 1'b0;
    num_a[d] = 8'h00; num_b[d] = 8'h00;
    tick();
    rst[d] = 1'b0;
  endtask

  // Raise one request, wait (bounded) for its ack, then drop it.
  task automatic save(input int d, input bit is_b, input logic [7:0] val);
    bit seen = 1'b0;
    if (is_b) begin req_b[d] = 1'b1; num_b[d] = val; end
    else      begin req_a[d] = 1'b1; num_a[d] = val; end
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (is_b ? ack_b[d] : ack_a[d]) seen = 1'b1;
    end
    chk($sformatf("save_ack.d%0d.%0h", d, val), 32'(seen), 32'd1);
    if (is_b) req_b[d] = 1'b0;
    else      req_a[d] = 1'b0;
  endtask

  // ---------------- directed table --------------------------------------
  typedef struct {
    logic       rst, a;
    logic [7:0] na;
    logic       b;
    logic [7:0] nb;
    logic       c;
    logic [3:0] ok;
    logic [7:0] nm;
    logic       aa, ab;
    logic [1:0] wr;
    logic [2:0] cnt;
    logic       f;
  } vec_t;

  function automatic vec_t v(logic r, logic a, logic [7:0] na, logic b, logic [7:0] nb,
                             logic c, logic [3:0] ok, logic [7:0] nm, logic aa,
                             logic ab, logic [1:0] wr, logic [2:0] cnt, logic f);
    vec_t x;
    x.rst = r; x.a = a; x.na = na; x.b = b; x.nb = nb; x.c = c;
    x.ok = ok; x.nm = nm; x.aa = aa; x.ab = ab; x.wr = wr; x.cnt = cnt; x.f = f;
    return x;
  endfunction

  vec_t tbl [23];

  // ---------------- reference model -------------------------------------
  // The model is a timeline of output frames: a grant schedules the write
  // frame now plus the ack and idle frames for the next two edges; a clear
  // schedules the clear frame plus one idle frame.
  typedef struct {
    logic [3:0] ok;
    logic [7:0] nm;
    logic       aa, ab;
    logic [1:0] wr;
    logic [2:0] cnt;
  } frame_t;

  frame_t cur    [2];
  frame_t fut    [2][2];
  int     nfut   [2];
  bit     m_pend [2];
  bit     last_b [2];

  task automatic model_reset(input int d);
    frame_t z;
    z.ok = 4'h0; z.nm = 8'h00; z.aa = 1'b0; z.ab = 1'b0; z.wr = 2'd0; z.cnt = 3'd0;
    cur[d] = z; nfut[d] = 0; m_pend[d] = 1'b0; last_b[d] = 1'b1;
  endtask

  task automatic push(input int d, input frame_t f);
    fut[d][nfut[d]] = f;
    nfut[d]++;
  endtask

  task automatic model_step(input int d, input logic a, input logic [7:0] na,
                            input logic b, input logic [7:0] nb, input logic c);
    frame_t f;
    bit     pick_b;
    if (nfut[d] > 0) begin
      cur[d] = fut[d][0];
      fut[d][0] = fut[d][1];
      nfut[d]--;
      m_pend[d] = m_pend[d] | c;
    end else if (m_pend[d] || c) begin
      f.ok = 4'hF; f.nm = 8'h00; f.aa = 1'b0; f.ab = 1'b0; f.wr = 2'd0; f.cnt = 3'd0;
      cur[d] = f;
      f.ok = 4'h0;
      push(d, f);
      m_pend[d] = 1'b0;
    end else if ((a || b) && (cur[d].cnt < 3'd4 || d == 1)) begin
      pick_b = b && (!a || !last_b[d]);
      last_b[d] = pick_b;
      f = cur[d];
      f.ok = 4'b0001 << f.wr;
      f.nm = pick_b ? nb : na;
      f.aa = 1'b0; f.ab = 1'b0;
      cur[d] = f;
      f.ok = 4'h0; f.aa = !pick_b; f.ab = pick_b;
      f.wr = 2'((int'(f.wr) + 1) % 4);
      if (f.cnt < 3'd4) f.cnt = f.cnt + 3'd1;
      push(d, f);
      f.aa = 1'b0; f.ab = 1'b0;
      push(d, f);
    end else begin
      cur[d].ok = 4'h0; cur[d].aa = 1'b0; cur[d].ab = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_a[d] = 1'b0; req_b[d] = 1'b0; clr[d] = 1'b0;
      num_a[d] = 8'h00; num_b[d] = 8'h00;
    end

    //              rst a na    b nb    c  ok    nm    aa ab wr cnt f
    tbl[0]  = v(1, 0, 8'h00, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 0, 0, 0);
    tbl[1]  = v(0, 1, 8'h2A, 0, 8'h00, 0, 4'h1, 8'h2A, 0, 0, 0, 0, 0);
    tbl[2]  = v(0, 1, 8'h2A, 0, 8'h00, 0, 4'h0, 8'h2A, 1, 0, 1, 1, 0);
    tbl[3]  = v(0, 0, 8'h2A, 0, 8'h00, 0, 4'h0, 8'h2A, 0, 0, 1, 1, 0);
    tbl[4]  = v(1, 0, 8'h00, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 0, 0, 0);
    tbl[5]  = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h1, 8'h11, 0, 0, 0, 0, 0);
    tbl[6]  = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h0, 8'h11, 1, 0, 1, 1, 0);
    tbl[7]  = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h0, 8'h11, 0, 0, 1, 1, 0);
    tbl[8]  = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h2, 8'h22, 0, 0, 1, 1, 0);
    tbl[9]  = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h0, 8'h22, 0, 1, 2, 2, 0);
    tbl[10] = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h0, 8'h22, 0, 0, 2, 2, 0);
    tbl[11] = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h4, 8'h11, 0, 0, 2, 2, 0);
    tbl[12] = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h0, 8'h11, 1, 0, 3, 3, 0);
    tbl[13] = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h0, 8'h11, 0, 0, 3, 3, 0);
    tbl[14] = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h8, 8'h22, 0, 0, 3, 3, 0);
    tbl[15] = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h0, 8'h22, 0, 1, 0, 4, 1);
    tbl[16] = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h0, 8'h22, 0, 0, 0, 4, 1);
    tbl[17] = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h0, 8'h22, 0, 0, 0, 4, 1);
    tbl[18] = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h0, 8'h22, 0, 0, 0, 4, 1);
    tbl[19] = v(0, 1, 8'h11, 1, 8'h22, 1, 4'hF, 8'h00, 0, 0, 0, 0, 0);
    tbl[20] = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h0, 8'h00, 0, 0, 0, 0, 0);
    tbl[21] = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h1, 8'h11, 0, 0, 0, 0, 0);
    tbl[22] = v(0, 1, 8'h11, 1, 8'h22, 0, 4'h0, 8'h11, 1, 0, 1, 1, 0);

    @(negedge clk);
    for (int i = 0; i < 23; i++) begin
      rst[0] = tbl[i].rst; req_a[0] = tbl[i].a; num_a[0] = tbl[i].na;
      req_b[0] = tbl[i].b; num_b[0] = tbl[i].nb; clr[0] = tbl[i].c;
      tick();
      chk_out(0, $sformatf("tbl%0d", i), tbl[i].ok, tbl[i].nm, tbl[i].aa,
              tbl[i].ab, tbl[i].wr, tbl[i].cnt, tbl[i].f);
    end

    // Full with stalling: B waits until a clear, then lands in slot 0.
    do_reset(0);
    for (int k = 0; k < 4; k++) save(0, 1'b0, 8'(8'h10 + k));
    chk("stall.full", 32'(full[0]), 32'd1);
    chk("stall.count", 32'(count[0]), 32'd4);
    req_b[0] = 1'b1; num_b[0] = 8'h77;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("stall.ok_save%0d", k), 32'(ok_save[0]), 32'd0);
      chk($sformatf("stall.ack_b%0d", k), 32'(ack_b[0]), 32'd0);
    end
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("stall.clr_ok", 32'(ok_save[0]), 32'hF);
    chk("stall.clr_num", 32'(num[0]), 32'd0);
    chk("stall.clr_count", 32'(count[0]), 32'd0);
    tick();
    chk("stall.idle_ok", 32'(ok_save[0]), 32'd0);
    tick();
    chk("stall.wr_ok", 32'(ok_save[0]), 32'h1);
    chk("stall.wr_num", 32'(num[0]), 32'h77);
    tick();
    chk("stall.ack_b", 32'(ack_b[0]), 32'd1);
    chk("stall.wr_ptr", 32'(wr_ptr[0]), 32'd1);
    chk("stall.count1", 32'(count[0]), 32'd1);
    req_b[0] = 1'b0;

    // Overwrite when full: slot 0 is rewritten, count stays at 4.
    do_reset(1);
    for (int k = 0; k < 4; k++) save(1, k[0], 8'(k + 1));
    chk("ovw.full", 32'(full[1]), 32'd1);
    chk("ovw.wr_ptr0", 32'(wr_ptr[1]), 32'd0);
    req_a[1] = 1'b1; num_a[1] = 8'h55;
    tick();
    tick();
    chk("ovw.ok", 32'(ok_save[1]), 32'h1);
    chk("ovw.num", 32'(num[1]), 32'h55);
    tick();
    chk("ovw.ack_a", 32'(ack_a[1]), 32'd1);
    chk("ovw.wr_ptr", 32'(wr_ptr[1]), 32'd1);
    chk("ovw.count", 32'(count[1]), 32'd4);
    chk("ovw.full4", 32'(full[1]), 32'd1);
    req_a[1] = 1'b0;

    // Clear pulsed during WRITE: the ack still completes, clear follows.
    do_reset(0);
    req_a[0] = 1'b1; num_a[0] = 8'h3C;
    tick();
    chk("clrw.ok", 32'(ok_save[0]), 32'h1);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0; req_a[0] = 1'b0;
    chk("clrw.ack_a", 32'(ack_a[0]), 32'd1);
    chk("clrw.count1", 32'(count[0]), 32'd1);
    tick();
    chk("clrw.idle_ok", 32'(ok_save[0]), 32'd0);
    tick();
    chk("clrw.clear_ok", 32'(ok_save[0]), 32'hF);
    chk("clrw.count0", 32'(count[0]), 32'd0);
    chk("clrw.wr_ptr0", 32'(wr_ptr[0]), 32'd0);

    // Reset during WRITE aborts the save without an ack.
    do_reset(0);
    req_a[0] = 1'b1; num_a[0] = 8'h66;
    tick();
    chk("rstw.ok", 32'(ok_save[0]), 32'h1);
    rst[0] = 1'b1;
    tick();
    chk_out(0, "rstw.after", 4'h0, 8'h00, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    rst[0] = 1'b0; req_a[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rstw.noack%0d", k), 32'(ack_a[0]), 32'd0);
    end

    // Randomized run of both instances against the model.
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_a[d] = 1'b0; req_b[d] = 1'b0; clr[d] = 1'b0;
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0;
      model_reset(d);
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        chk_out(d, $sformatf("rnd%0d.d%0d", cyc, d), cur[d].ok, cur[d].nm,
                cur[d].aa, cur[d].ab, cur[d].wr, cur[d].cnt, cur[d].cnt == 3'd4);
        if (req_a[d] && cur[d].aa) begin
          if ($urandom_range(1, 0) == 0) req_a[d] = 1'b0;
        end else if (!req_a[d] && $urandom_range(2, 0) == 0) begin
          req_a[d] = 1'b1; num_a[d] = 8'($urandom);
        end
        if (req_b[d] && cur[d].ab) begin
          if ($urandom_range(1, 0) == 0) req_b[d] = 1'b0;
        end else if (!req_b[d] && $urandom_range(2, 0) == 0) begin
          req_b[d] = 1'b1; num_b[d] = 8'($urandom);
        end
        clr[d] = ($urandom_range(15, 0) == 0);
        model_step(d, req_a[d], num_a[d], req_b[d], num_b[d], clr[d]);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
